// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module : usb_pkg
// Brief  : Shared USB receive-path constants (bit timing, byte size,
//          bit-stuffing run length).
// Rev    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    // 96 MHz system clock over 12 Mbps full-speed line rate
    localparam int USB_CLKS_PER_BIT  = 8;
    // Clock-counter value at which the line is sampled
    localparam int USB_SAMPLE_POINT  = 3;
    localparam int USB_BITS_PER_BYTE = 8;
    // Ones in a row after which the transmitter inserts a stuffed zero
    localparam int USB_STUFF_RUN     = 6;

endpackage
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module : flex_counter
// Brief  : Generic up-counter with synchronous clear and programmable
//          rollover. Counts 1..rollover_val and wraps rollover_val -> 1.
//          clear has priority over count_enable and loads 0.
// Ports  : clk, n_rst (async active-low)
//          clear         - synchronous clear to 0
//          count_enable  - advance the count this cycle
//          rollover_val  - last value before wrapping back to 1
//          count_out     - registered count
// Rev    : 1.0 - initial release
// ============================================================================
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    localparam logic [NUM_CNT_BITS-1:0] C_ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic [NUM_CNT_BITS-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (clear) begin
            w_next = '0;
        end else if (count_enable) begin
            if (r_count == rollover_val) begin
                w_next = C_ONE;
            end else begin
                w_next = r_count + C_ONE;
            end
        end
    end

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count_out = r_count;

endmodule
`default_nettype wire

// File: rtl/usb_rx_timer.sv
`default_nettype none
// ============================================================================
// Module : usb_rx_timer
// Brief  : USB receive bit-timing stage. Tracks bit phase with a clock-in-bit
//          counter (resynchronised on line edges), strobes shift_enable once
//          per bit at SAMPLE_POINT, counts bits per byte and pulses
//          byte_received after the 8th shift.
//          Optional feature macro USB_RX_TIMER_STUFF_EN: removes stuffed bits
//          after a run of six ones and pulses stuff_error on a violation.
// Ports  : clk, n_rst (async active-low)
//          enable_timer  - high for the duration of a packet
//          d_edge        - one-cycle pulse on any line transition
//          d_orig        - decoded bit value, valid at the sample point
//          shift_enable  - one-cycle shift strobe
//          byte_received - one-cycle pulse the cycle after the 8th shift
//          bit_cnt       - shifts taken in the current byte
//          stuff_error   - one-cycle pulse on a stuffing violation
// Rev    : 1.0 - initial release
// ============================================================================
module usb_rx_timer
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int SAMPLE_POINT = USB_SAMPLE_POINT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable_timer,
    input  logic       d_edge,
    input  logic       d_orig,
    output logic       shift_enable,
    output logic       byte_received,
    output logic [3:0] bit_cnt,
    output logic       stuff_error
);

    localparam logic [3:0] C_CLKS_PER_BIT  = 4'(CLKS_PER_BIT);
    localparam logic [3:0] C_SAMPLE_POINT  = 4'(SAMPLE_POINT);
    localparam logic [3:0] C_BITS_PER_BYTE = 4'(USB_BITS_PER_BYTE);

    logic [3:0] w_clk_cnt;
    logic [3:0] w_clk_rollover;
    logic [3:0] w_bit_cnt_raw;
    logic       w_sample;
    logic       w_stuff_bit;
    logic       w_byte_done;
    logic       w_bit_clear;

    // ------------------------------------------------------------------
    // Clock-in-bit counter. Held at 0 while disabled; the first enabled
    // cycle advances 0 -> 1. On a line edge the rollover target is pointed
    // at the current count, so the counter wraps to 1 on the next cycle
    // whatever its present value: this is the resync.
    // ------------------------------------------------------------------
    assign w_clk_rollover = d_edge ? w_clk_cnt : C_CLKS_PER_BIT;

    flex_counter #(
        .NUM_CNT_BITS (4)
    ) u_clk_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (~enable_timer),
        .count_enable (enable_timer),
        .rollover_val (w_clk_rollover),
        .count_out    (w_clk_cnt)
    );

    assign w_sample = enable_timer && (w_clk_cnt == C_SAMPLE_POINT);

    // ------------------------------------------------------------------
    // Bit stuffing
    // ------------------------------------------------------------------
`ifdef USB_RX_TIMER_STUFF_EN
    localparam logic [2:0] C_STUFF_RUN = 3'(USB_STUFF_RUN);

    logic [2:0] r_ones_run;

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            r_ones_run <= '0;
        end else if (!enable_timer) begin
            r_ones_run <= '0;
        end else if (w_sample) begin
            if (w_stuff_bit || !d_orig) begin
                r_ones_run <= '0;
            end else begin
                r_ones_run <= r_ones_run + 3'd1;
            end
        end
    end

    // The sample following a full run of ones is the inserted zero; a one
    // there means the transmitter broke the stuffing rule.
    assign w_stuff_bit = w_sample && (r_ones_run == C_STUFF_RUN);
    assign stuff_error = w_stuff_bit && d_orig;
`else
    logic w_unused_d_orig;
    assign w_unused_d_orig = d_orig;
    assign w_stuff_bit     = 1'b0;
    assign stuff_error     = 1'b0;
`endif

    assign shift_enable = w_sample && !w_stuff_bit;

    // ------------------------------------------------------------------
    // Bit-in-byte counter. Reaching 8 marks a completed byte for exactly
    // one cycle: byte_received is decoded from it and bit_cnt reads 0.
    // The counter is then cleared, unless a shift lands in that same
    // cycle, in which case the natural wrap 8 -> 1 keeps that bit.
    // ------------------------------------------------------------------
    assign w_byte_done = (w_bit_cnt_raw == C_BITS_PER_BYTE);
    assign w_bit_clear = ~enable_timer | (w_byte_done & ~shift_enable);

    flex_counter #(
        .NUM_CNT_BITS (4)
    ) u_bit_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_bit_clear),
        .count_enable (shift_enable),
        .rollover_val (C_BITS_PER_BYTE),
        .count_out    (w_bit_cnt_raw)
    );

    assign byte_received = enable_timer && w_byte_done;
    assign bit_cnt       = w_byte_done ? 4'd0 : w_bit_cnt_raw;

endmodule
`default_nettype wire
